split_display_sequencer: RTL and testbench
==========================================

Name: split_display_sequencer

Overview:
- KPN Split process stage that sits directly upstream of the LCD writer in the Split module.
- Reads 16-bit tokens from an input channel FIFO and routes them alternately to two output channel FIFOs: token 0 to channel 1, token 1 to channel 2, and so on.
- Holds the last entry and the last token on each output as display registers.
- Sequences the LCD writer's show strobes, and the writer reset it needs, for each token.

Parameters:
- DATA_WIDTH, 16, token width; must equal the LCD writer's entry/output width.
- DWELL_CYCLES, 50000000, clock cycles each LCD screen is held; minimum 2.
- CNT_WIDTH, 26, dwell counter width; must satisfy 2^CNT_WIDTH > DWELL_CYCLES.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_data  in  16  input FIFO head; first-word-fall-through, valid whenever in_empty=0
- in_empty  in  1  input FIFO empty
- in_rd_en  out  1  one-cycle pop strobe
- out1_data  out  16  channel-1 write data
- out1_full  in  1  channel-1 FIFO full
- out1_wr_en  out  1  channel-1 write strobe
- out2_data  out  16  channel-2 write data
- out2_full  in  1  channel-2 FIFO full
- out2_wr_en  out  1  channel-2 write strobe
- entry_1  out  16  last token read (to LCD writer)
- output_1  out  16  last token sent on channel 1
- output_2  out  16  last token sent on channel 2
- show_entry_1  out  1  level request: show entry screen
- show_output_1  out  1  level request: show output line 1
- show_output_2  out  1  level request: show output line 2
- lcd_reset  out  1  one-cycle reset pulse to the LCD writer, which rearms its finished flags
- entry_1_finished  in  1  from the LCD writer; entry screen fully written
- busy  out  1  high in every state except IDLE

Behaviour:

Reset (synchronous, active-high):
- All outputs go to 0.
- Internal state: toggle sel=0, dwell counter=0, state=IDLE.
- Reset asserted mid-operation aborts immediately. No FIFO strobe is issued in the reset cycle. Tokens already popped but not yet written are lost.

FSM, one state per cycle unless noted:
- IDLE: if in_empty=0, go to READ; otherwise stay.
- READ:
  - in_rd_en=1 for this cycle only.
  - entry_1 <= in_data, and the token is captured into an internal register.
  - Go to WRITE.
- WRITE:
  - The target channel is sel (0 = channel 1, 1 = channel 2).
  - While the target FIFO is full, stay in WRITE and issue no strobe. The wait is unbounded.
  - When not full: drive outN_wr_en=1 for one cycle with outN_data = token, set output_N <= token, toggle sel, go to LCD_RST.
  - The non-target channel's full flag is ignored.
- LCD_RST: lcd_reset=1 for one cycle; go to SHOW_ENTRY.
- SHOW_ENTRY:
  - Hold show_entry_1=1 and clear the dwell counter.
  - When entry_1_finished=1, drop show_entry_1 and go to DWELL_ENTRY.
  - Timeout: if finished has not arrived after 4*DWELL_CYCLES, go to DWELL_ENTRY anyway.
- DWELL_ENTRY: count to DWELL_CYCLES-1, then go to SHOW_OUT.
- SHOW_OUT:
  - Hold show_output_1=1 and show_output_2=1 together; the LCD writer's internal priority draws line 1 and then line 2.
  - Count DWELL_CYCLES, then drop both strobes and go to IDLE.

Timing and boundary rules:
- in_rd_en and outN_wr_en are never high in the same cycle.
- Each token produces exactly one read and exactly one write.
- Channel selection strictly alternates and survives FIFO stalls; sel toggles only on an actual write.
- Display registers change only in READ and WRITE and are stable during all SHOW states.
- Best-case latency: a token present in IDLE at cycle t gives in_rd_en at t+1, wr_en at t+2, lcd_reset at t+3, show_entry_1 from t+4.
- The input FIFO is never popped outside READ, so back-pressure propagates upstream.
- An entry_1_finished pulse seen outside SHOW_ENTRY is ignored.

Decomposition:
- Shared package split_pkg holds:
  - the state enum: IDLE, READ, WRITE, LCD_RST, SHOW_ENTRY, DWELL_ENTRY, SHOW_OUT
  - localparam TOKEN_W=16
  - the channel-select encoding CH1=0, CH2=1
- One natural sub-module, dwell_timer: loadable counter with a clear input and a terminal-count output at a programmable limit. It is used for both the dwell and the timeout.
- Everything else stays inline.

Test Plan (DWELL_CYCLES=8 on the bench):
1. Reset mid-SHOW_OUT → next cycle all outputs are 0 and state is IDLE. A token 0x1234 pushed afterwards goes to channel 1.
2. Push token 0xA5A5 into an empty system, both channels non-full, LCD model asserting finished 5 cycles after show_entry_1 → required sequence:
   - in_rd_en at t+1
   - out1_wr_en with 0xA5A5 at t+2, output_1=0xA5A5
   - lcd_reset at t+3
   - show_entry_1 from t+4 until finished
   - 8 dwell cycles
   - show_output_1 and show_output_2 high for 8 cycles
3. Push 0x0001, 0x0002, 0x0003 → channel 1 receives 0x0001 and 0x0003, channel 2 receives 0x0002, output_2=0x0002. Exactly 3 reads and 3 writes.
4. Push 0x00FF while out1_full=1 for 20 cycles, with out2_full toggling → no strobe during the stall. A single out1_wr_en fires on the cycle after out1_full falls; entry_1 holds 0x00FF throughout.
5. LCD model never asserts entry_1_finished → SHOW_ENTRY exits after 32 cycles and the sequence completes normally.
6. An entry_1_finished pulse injected during IDLE, then token 0xBEEF → the pulse is ignored; SHOW_ENTRY still waits for a fresh finished.

Source files
------------

// File: rtl/split_pkg.sv
// Shared types and constants for the split display sequencer.
// Holds the sequencer state encoding, token width and channel-select values.
package split_pkg;

  localparam int unsigned TOKEN_W = 16;

  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StLcdRst,
    StShowEntry,
    StDwellEntry,
    StShowOut
  } state_e;

endpackage

// File: rtl/split_display_sequencer_dwell_timer.sv
// Up-counter with synchronous clear and a terminal-count flag at a programmable limit.
// Saturates at the limit so a late clear never sees a wrapped count.
module split_display_sequencer_dwell_timer #(
  parameter int unsigned Width = 28
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [Width-1:0] limit_i,
  output logic             done_o
);

  logic [Width-1:0] count_q, count_d;

  assign done_o = (count_q == limit_i);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !done_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/split_display_sequencer.sv
// Split stage ahead of the LCD writer: pops tokens, routes them alternately to two
// output FIFOs, keeps display registers and sequences the writer's show/reset strobes.
module split_display_sequencer
  import split_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = TOKEN_W,
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned CNT_WIDTH    = 26
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out1_data,
  input  logic                  out1_full,
  output logic                  out1_wr_en,
  output logic [DATA_WIDTH-1:0] out2_data,
  input  logic                  out2_full,
  output logic                  out2_wr_en,
  output logic [DATA_WIDTH-1:0] entry_1,
  output logic [DATA_WIDTH-1:0] output_1,
  output logic [DATA_WIDTH-1:0] output_2,
  output logic                  show_entry_1,
  output logic                  show_output_1,
  output logic                  show_output_2,
  output logic                  lcd_reset,
  input  logic                  entry_1_finished,
  output logic                  busy
);

  // Two extra bits so the 4x timeout limit fits alongside the dwell limit.
  localparam int unsigned TimerW = CNT_WIDTH + 2;
  localparam logic [TimerW-1:0] DwellLimit   = TimerW'(DWELL_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLimit = TimerW'(4 * DWELL_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  sel_q;
  logic [DATA_WIDTH-1:0] token_q, entry_q, out1_q, out2_q;

  logic              target_full;
  logic              write_go;
  logic              timer_clear;
  logic              timer_en;
  logic              timer_done;
  logic [TimerW-1:0] timer_limit;

  assign target_full = (sel_q == CH1) ? out1_full : out2_full;
  assign write_go    = (state_q == StWrite) && !target_full;

  // Counter restarts from zero on every state change.
  assign timer_clear = (state_d != state_q);
  assign timer_en    = state_q inside {StShowEntry, StDwellEntry, StShowOut};
  assign timer_limit = (state_q == StShowEntry) ? TimeoutLimit : DwellLimit;

  split_display_sequencer_dwell_timer #(
    .Width(TimerW)
  ) u_dwell_timer (
    .clock   (clock),
    .reset   (reset),
    .clear_i (timer_clear),
    .enable_i(timer_en),
    .limit_i (timer_limit),
    .done_o  (timer_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:       if (!in_empty) state_d = StRead;
      StRead:       state_d = StWrite;
      StWrite:      if (!target_full) state_d = StLcdRst;
      StLcdRst:     state_d = StShowEntry;
      StShowEntry:  if (entry_1_finished || timer_done) state_d = StDwellEntry;
      StDwellEntry: if (timer_done) state_d = StShowOut;
      StShowOut:    if (timer_done) state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q   <= CH1;
      token_q <= '0;
      entry_q <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      if (state_q == StRead) begin
        token_q <= in_data;
        entry_q <= in_data;
      end
      if (write_go) begin
        if (sel_q == CH1) begin
          out1_q <= token_q;
        end else begin
          out2_q <= token_q;
        end
        sel_q <= ~sel_q;
      end
    end
  end

  // Strobes are masked during reset so an aborted cycle issues no FIFO traffic.
  always_comb begin
    in_rd_en      = 1'b0;
    out1_wr_en    = 1'b0;
    out2_wr_en    = 1'b0;
    lcd_reset     = 1'b0;
    show_entry_1  = 1'b0;
    show_output_1 = 1'b0;
    show_output_2 = 1'b0;
    busy          = 1'b0;
    if (!reset) begin
      in_rd_en      = (state_q == StRead);
      out1_wr_en    = write_go && (sel_q == CH1);
      out2_wr_en    = write_go && (sel_q == CH2);
      lcd_reset     = (state_q == StLcdRst);
      show_entry_1  = (state_q == StShowEntry);
      show_output_1 = (state_q == StShowOut);
      show_output_2 = (state_q == StShowOut);
      busy          = (state_q != StIdle);
    end
  end

  assign out1_data = token_q;
  assign out2_data = token_q;
  assign entry_1   = entry_q;
  assign output_1  = out1_q;
  assign output_2  = out2_q;

endmodule

// File: tb/tb_split_display_sequencer.sv
// Bench for split_display_sequencer: directed timeline checks plus a randomized run
// scored against token-order routing with FIFO and LCD-writer models.
module tb_split_display_sequencer;

  localparam int D = 8;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_empty = 1'b1;
  logic         in_rd_en;
  logic [W-1:0] out1_data, out2_data;
  logic         out1_full = 1'b0, out2_full = 1'b0;
  logic         out1_wr_en, out2_wr_en;
  logic [W-1:0] entry_1, output_1, output_2;
  logic         show_entry_1, show_output_1, show_output_2, lcd_reset;
  logic         entry_1_finished = 1'b0;
  logic         busy;

  always #5 clock = ~clock;

  split_display_sequencer #(
    .DATA_WIDTH  (W),
    .DWELL_CYCLES(D),
    .CNT_WIDTH   (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_data         (in_data),
    .in_empty        (in_empty),
    .in_rd_en        (in_rd_en),
    .out1_data       (out1_data),
    .out1_full       (out1_full),
    .out1_wr_en      (out1_wr_en),
    .out2_data       (out2_data),
    .out2_full       (out2_full),
    .out2_wr_en      (out2_wr_en),
    .entry_1         (entry_1),
    .output_1        (output_1),
    .output_2        (output_2),
    .show_entry_1    (show_entry_1),
    .show_output_1   (show_output_1),
    .show_output_2   (show_output_2),
    .lcd_reset       (lcd_reset),
    .entry_1_finished(entry_1_finished),
    .busy            (busy)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  int reads = 0, writes = 0, nw = 0;
  logic [W-1:0] in_q[$], pend[$], tok_log[$];
  bit   sel_model = 1'b0;
  int   lat = 5, se_cnt = 0;
  bit   fin = 1'b0;
  bit   directed = 1'b1;
  int   cur_off = 0, stall_len = 0;
  bit   stall_ch = 1'b0;

  // Sampled vector: busy, rd, wr1, wr2, lcd_reset, show_entry, show_out1, show_out2
  logic [7:0]   s_vec;
  logic [W-1:0] s_d1, s_d2, s_entry, s_o1, s_o2;
  logic         s_f1, s_f2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_inputs();
    bit stalled;
    in_empty = (in_q.size() == 0);
    in_data  = in_empty ? '0 : in_q[0];
    entry_1_finished = fin;
    if (directed) begin
      stalled = (cur_off < stall_len);
      if (stall_ch == 1'b0) begin
        out1_full = stalled;
        out2_full = stalled && ($urandom_range(0, 1) == 1);
      end else begin
        out2_full = stalled;
        out1_full = stalled && ($urandom_range(0, 1) == 1);
      end
    end else begin
      out1_full = ($urandom_range(0, 2) == 0);
      out2_full = ($urandom_range(0, 2) == 0);
    end
  endtask

  // One clock: sample at the falling edge, then apply FIFO and LCD-writer effects.
  task automatic step();
    @(negedge clock);
    s_vec   = {busy, in_rd_en, out1_wr_en, out2_wr_en, lcd_reset, show_entry_1,
               show_output_1, show_output_2};
    s_d1    = out1_data;
    s_d2    = out2_data;
    s_entry = entry_1;
    s_o1    = output_1;
    s_o2    = output_2;
    s_f1    = out1_full;
    s_f2    = out2_full;
    @(posedge clock);
    #1;
    cyc++;
    if (s_vec[6]) begin
      reads++;
      if (in_q.size() > 0) void'(in_q.pop_front());
    end
    if (s_vec[5] || s_vec[4]) writes++;
    if (s_vec[3]) begin
      fin = 1'b0;
      se_cnt = 0;
      if (!directed) lat = $urandom_range(0, 6);
    end else if (s_vec[2] && lat != 0) begin
      se_cnt++;
      if (se_cnt >= lat) fin = 1'b1;
    end
    cur_off++;
    set_inputs();
  endtask

  // Offset 0 is the IDLE cycle where the token first becomes visible.
  function automatic logic [7:0] exp_vec(input int o, input int w, input int l, input bit ch);
    int   se0, dw0, so0, e;
    logic so;
    se0 = w + 2;
    dw0 = se0 + l;
    so0 = dw0 + D;
    e   = so0 + D;
    so  = (o >= so0) && (o < e);
    return {(o >= 1) && (o < e), o == 1, (o == w) && !ch, (o == w) && ch, o == w + 1,
            (o >= se0) && (o < dw0), so, so};
  endfunction

  task automatic push_token(input logic [W-1:0] t);
    in_q.push_back(t);
    pend.push_back(t);
    tok_log.push_back(t);
    set_inputs();
  endtask

  task automatic run_seq(input int stall, input int l);
    logic [W-1:0] tok;
    bit ch;
    int w, e;
    tok = pend.pop_front();
    ch = sel_model;
    sel_model = ~sel_model;
    w = (stall > 2) ? stall : 2;
    e = w + 2 + l + 2 * D;
    stall_len = stall;
    stall_ch = ch;
    cur_off = 0;
    set_inputs();
    for (int o = 0; o < e; o++) begin
      step();
      check_eq("seq", {24'h0, s_vec}, {24'h0, exp_vec(o, w, l, ch)});
      if (o == w) check_eq("wdata", ch ? s_d2 : s_d1, tok);
      if (o >= 2) check_eq("entry_1", s_entry, tok);
      if (o > w) check_eq(ch ? "output_2" : "output_1", ch ? s_o2 : s_o1, tok);
    end
    stall_len = 0;
  endtask

  task automatic check_idle();
    step();
    check_eq("idle", {24'h0, s_vec}, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_q.delete();
    pend.delete();
    fin = 1'b0;
    se_cnt = 0;
    sel_model = 1'b0;
    set_inputs();
    step();
    check_eq("rst_strobes", {29'h0, s_vec[6:4]}, 32'h0);
    reset = 1'b0;
    step();
    check_eq("rst_vec", {24'h0, s_vec}, 32'h0);
    check_eq("rst_entry", s_entry, 0);
    check_eq("rst_out1", s_o1, 0);
    check_eq("rst_out2", s_o2, 0);
    check_eq("rst_data", {s_d1, s_d2}, 0);
  endtask

  task automatic rand_check();
    bit ch;
    logic [W-1:0] exp;
    if (s_vec[6]) check_eq("rd_excl", {30'h0, s_vec[5:4]}, 32'h0);
    if (s_vec[5] || s_vec[4]) begin
      ch  = s_vec[4];
      exp = (nw < tok_log.size()) ? tok_log[nw] : 16'hDEAD;
      check_eq("rand_chan", {31'h0, ch}, nw % 2);
      check_eq("rand_full", {31'h0, ch ? s_f2 : s_f1}, 32'h0);
      check_eq("rand_data", ch ? s_d2 : s_d1, exp);
      check_eq("rand_entry", s_entry, exp);
      nw++;
    end
    if ((s_vec[2] || s_vec[1]) && nw > 0) begin
      check_eq("rand_disp", ((nw - 1) % 2 == 1) ? s_o2 : s_o1, tok_log[nw - 1]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int r0, w0, pushed;

    // Reset in the middle of SHOW_OUT, then a fresh token must land on channel 1.
    lat = 3;
    do_reset();
    push_token(16'h5555);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (s_vec[1]) found = 1'b1;
    end
    check_eq("reach_show_out", {31'h0, found}, 32'h1);
    step();
    step();
    do_reset();
    push_token(16'h1234);
    run_seq(0, lat + 1);
    check_idle();

    // Best-case single-token timeline.
    do_reset();
    lat = 5;
    push_token(16'hA5A5);
    run_seq(0, lat + 1);
    check_idle();

    // Three back-to-back tokens alternate channels.
    do_reset();
    lat = 2;
    r0 = reads;
    w0 = writes;
    push_token(16'h0001);
    push_token(16'h0002);
    push_token(16'h0003);
    run_seq(0, lat + 1);
    run_seq(0, lat + 1);
    run_seq(0, lat + 1);
    check_idle();
    check_eq("t3_reads", reads - r0, 3);
    check_eq("t3_writes", writes - w0, 3);

    // Channel-1 stall for 20 cycles with the other full flag toggling.
    do_reset();
    lat = 4;
    push_token(16'h00FF);
    run_seq(20, lat + 1);
    check_idle();

    // Writer never finishes: SHOW_ENTRY times out after 4 dwell periods.
    lat = 0;
    push_token(16'h0F0F);
    run_seq(0, 4 * D);
    check_idle();

    // Stray finished pulse in IDLE must not shorten SHOW_ENTRY.
    lat = 5;
    fin = 1'b1;
    set_inputs();
    step();
    check_eq("t6_idle", {24'h0, s_vec}, 32'h0);
    fin = 1'b0;
    set_inputs();
    push_token(16'hBEEF);
    run_seq(0, lat + 1);
    check_idle();

    // Randomized traffic, back-pressure and writer latency.
    do_reset();
    directed = 1'b0;
    tok_log.delete();
    nw = 0;
    reads = 0;
    writes = 0;
    pushed = 0;
    lat = $urandom_range(0, 6);
    for (int c = 0; c < 20000 && !(pushed == 30 && writes == 30 && s_vec == 8'h0 &&
                                   in_q.size() == 0); c++) begin
      if (pushed < 30 && $urandom_range(0, 7) == 0) begin
        push_token(W'($urandom));
        pushed++;
      end
      step();
      rand_check();
    end
    check_eq("rand_reads", reads, 30);
    check_eq("rand_writes", writes, 30);
    check_eq("rand_done_idle", {24'h0, s_vec}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
